rgb2pix: RTL and testbench
==========================

# rgb2pix

Pipelined inverse of the grey false-colour map. Accepts a stream of 24-bit RGB pixels, e.g. captured or rendered frames fed back into the spectrogram path. Reduces each pixel to 8-bit luma and inverts the grey table, so `rgb2pix(bwmap(p)) == p` for p in 2..254. Also checks line length on the stream and flags framing errors.

## Interface
- `LINE_WORDS`, default 640: expected beats per line (1..4095).
- `i_clk`  in  1: system clock.
- `i_reset`  in  1: asynchronous, active-high reset.
- `s_valid`  in  1: input beat valid.
- `s_ready`  out  1: input beat accepted when `s_valid && s_ready`.
- `s_data`  in  24: pixel {R[23:16], G[15:8], B[7:0]}.
- `s_last`  in  1: last beat of line.
- `s_user`  in  1: first beat of frame.
- `m_valid`  out  1: output beat valid.
- `m_ready`  in  1: downstream ready.
- `m_data`  out  8: pixel index.
- `m_last`  out  1: `s_last` delayed with its beat.
- `m_user`  out  1: `s_user` delayed with its beat.
- `i_clr_err`  in  1: clears `o_line_err`.
- `o_line_err`  out  1: sticky line-length error.

## Operation
- Luma: Y = (77·R + 150·G + 29·B + 128) >> 8.
  - Products are unsigned, 16 bits; the sum is 16 bits, max 65408, no overflow.
  - Y is bits [15:8] of the sum.
- Inverse map:
  - Y==0 → 0.
  - 1 ≤ Y ≤ 253 → Y+1.
  - Y ≥ 254 → 254. Index 255 is never emitted.
- `s_last` and `s_user` travel alongside their pixel through every stage, unmodified.
- Line checker, on accepted beats only. `cnt` is 12 bits and resets to 0.
  - `s_user` accepted: this beat counts as beat 0.
  - `s_last` accepted with `cnt+1 != LINE_WORDS`: set error; `cnt` ← 0.
  - `s_last` accepted with `cnt+1 == LINE_WORDS`: `cnt` ← 0, no error.
  - Non-last beat accepted with `cnt+1 == LINE_WORDS`: set error; `cnt` ← 0.
  - Otherwise `cnt` ← `cnt+1`.
- `s_user` and `s_last` on the same beat: a one-beat line, valid only if `LINE_WORDS==1`.
- `o_line_err` is sticky until `i_clr_err` is asserted. A set and a clear in the same cycle: set wins.

## Timing
- Three register stages, each with its own valid bit:
  - S1: three registered products, plus last/user.
  - S2: registered rounded sum.
  - S3: inverse-map result; this is the output register.
- Latency: 3 cycles from acceptance to `m_valid` with no stall.
- Throughput: 1 beat/cycle while `m_ready` is high.
- Stage k loads when stage k is empty or is passing its beat on in the same cycle.
  - S3 passes on when `m_valid && m_ready`.
  - `s_ready = !v1 || (S1 passes on to S2)`. It is purely combinational from the stage valids and `m_ready`.
  - Bubbles collapse during a stall: up to 3 beats are held while `m_ready` is low.
- `m_data`, `m_last` and `m_user` are held stable while `m_valid && !m_ready`.
- Reset values:
  - All valid bits 0, so `m_valid`=0 and `s_ready`=1 one cycle after reset release.
  - `m_data`=0, `m_last`=0, `m_user`=0.
  - `cnt`=0, `o_line_err`=0.
- Reset mid-frame discards every in-flight beat. No partial output follows reset.

## Structure
- Shared package `fftdemo_pkg` holds:
  - `COEF_R=77`, `COEF_G=150`, `COEF_B=29`, `ROUND=128`;
  - `PIX_MAX=254`;
  - `pix_t` (8-bit) and `rgb_t` (24-bit packed struct).
- One sub-module, `luma_mac`: stages S1–S2, carrying last/user as payload, with valid/ready on both sides.
- Top level contains S3, the inverse map and the line checker.

## Test plan
- Single beats, `m_ready`=1:
  - 0x000000 → 0
  - 0x010101 → 2
  - 0x646464 → 101
  - 0xFF0000 → 78
  - 0x00FF00 → 150
  - 0xFFFFFF → 254
  - Each appears exactly 3 cycles after acceptance.
- Round trip: for p = 2..254, drive grey (p−1)·0x010101 → `m_data`==p. Back-to-back, one per cycle, no gaps.
- Backpressure:
  - Hold `m_ready`=0 for 10 cycles mid-stream → `s_ready` falls after 3 accepted beats; output stays stable.
  - Release → the sequence resumes in order with no loss or duplication.
- Framing (`LINE_WORDS`=4):
  - Lines of 4 beats with `s_last` on beat 4 → `o_line_err` stays 0.
  - A 3-beat line → error set.
  - A 5-beat run with no `s_last` → error set at beat 4.
  - `i_clr_err` clears the error; a set and a clear in the same cycle leaves it set.
- Reset: assert `i_reset` with 3 beats in flight → `m_valid` drops immediately, no stale beats after release, `cnt` restarts at 0.

Source files
------------

// File: rtl/fftdemo_pkg.sv
// fftdemo_pkg
// Shared constants and types for the spectrogram demo datapath.
//   COEF_R/G/B, ROUND : fixed-point luma weights (x256) and rounding offset
//   PIX_MAX           : largest pixel index produced by the inverse grey map
//   pix_t             : 8-bit pixel index / luma value
//   rgb_t             : 24-bit packed RGB pixel {r, g, b}
//   inv_map()         : luma -> pixel index, the inverse of the grey colour table
package fftdemo_pkg;

    localparam logic [15:0] COEF_R  = 16'd77;
    localparam logic [15:0] COEF_G  = 16'd150;
    localparam logic [15:0] COEF_B  = 16'd29;
    localparam logic [15:0] ROUND   = 16'd128;

    typedef logic [7:0] pix_t;

    localparam pix_t PIX_MAX = 8'd254;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // The forward grey map sends index p to grey level p-1. Index 0 and the
    // top of the range cannot round-trip, so they saturate at the ends.
    function automatic pix_t inv_map(input pix_t y);
        if (y == 8'd0) begin
            return 8'd0;
        end else if (y >= PIX_MAX) begin
            return PIX_MAX;
        end else begin
            return y + 8'd1;
        end
    endfunction

endpackage

// File: rtl/rgb2pix_luma_mac.sv
// luma_mac
// Two-stage pipelined luma computation with valid/ready on both sides.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake
//   in_data             : RGB pixel
//   in_last, in_user    : sideband flags, carried unmodified with the pixel
//   out_valid/out_ready : downstream handshake
//   out_luma            : rounded luma Y = (77R + 150G + 29B + 128) >> 8
//   out_last, out_user  : sideband flags delayed with their pixel
module luma_mac
    import fftdemo_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  rgb_t in_data,
    input  logic in_last,
    input  logic in_user,
    output logic out_valid,
    input  logic out_ready,
    output pix_t out_luma,
    output logic out_last,
    output logic out_user
);

    logic        v1;
    logic        v2;
    logic [15:0] prod_r;
    logic [15:0] prod_g;
    logic [15:0] prod_b;
    logic        last1;
    logic        user1;
    pix_t        luma2;
    logic        last2;
    logic        user2;
    logic        load1;
    logic        load2;

    // A stage may load when it is empty or its content moves on this cycle;
    // this lets bubbles collapse while the output is stalled.
    assign load2    = !v2 || out_ready;
    assign load1    = !v1 || load2;
    assign in_ready = load1;

    // S1: three 8x8 products, each fits in 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            prod_r <= '0;
            prod_g <= '0;
            prod_b <= '0;
            last1  <= 1'b0;
            user1  <= 1'b0;
        end else if (load1) begin
            v1 <= in_valid;
            if (in_valid) begin
                prod_r <= 16'(in_data.r) * COEF_R;
                prod_g <= 16'(in_data.g) * COEF_G;
                prod_b <= 16'(in_data.b) * COEF_B;
                last1  <= in_last;
                user1  <= in_user;
            end
        end
    end

    // S2: the weights sum to 256, so the rounded sum tops out at 65408 and
    // the 16-bit add cannot overflow; only the integer part is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            luma2 <= '0;
            last2 <= 1'b0;
            user2 <= 1'b0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                luma2 <= 8'((prod_r + prod_g + prod_b + ROUND) >> 8);
                last2 <= last1;
                user2 <= user1;
            end
        end
    end

    assign out_valid = v2;
    assign out_luma  = luma2;
    assign out_last  = last2;
    assign out_user  = user2;

endmodule

// File: rtl/rgb2pix.sv
// rgb2pix
// Converts a stream of RGB pixels back to grey-map pixel indices and checks
// the length of every line in the stream.
//   LINE_WORDS          : expected beats per line (1..4095)
//   i_clk, i_reset      : clock, asynchronous active-high reset
//   s_valid/s_ready     : input handshake
//   s_data              : RGB pixel {R, G, B}
//   s_last, s_user      : last beat of line, first beat of frame
//   m_valid/m_ready     : output handshake
//   m_data              : pixel index
//   m_last, m_user      : sideband flags delayed with their pixel
//   i_clr_err           : clears the sticky line error
//   o_line_err          : sticky line-length error
module rgb2pix
    import fftdemo_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 640
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic        s_last,
    input  logic        s_user,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        m_user,
    input  logic        i_clr_err,
    output logic        o_line_err
);

    localparam logic [11:0] LINE_END = 12'(LINE_WORDS);

    logic        luma_valid;
    logic        luma_ready;
    pix_t        luma;
    logic        luma_last;
    logic        luma_user;
    logic        v3;
    logic        load3;
    logic        accept;
    logic [11:0] cnt;
    logic [11:0] cnt_base;
    logic [11:0] cnt_next;
    logic        line_full;
    logic        err_set;

    luma_mac u_luma_mac (
        .clk       (i_clk),
        .rst       (i_reset),
        .in_valid  (s_valid),
        .in_ready  (s_ready),
        .in_data   (rgb_t'(s_data)),
        .in_last   (s_last),
        .in_user   (s_user),
        .out_valid (luma_valid),
        .out_ready (luma_ready),
        .out_luma  (luma),
        .out_last  (luma_last),
        .out_user  (luma_user)
    );

    assign load3      = !v3 || m_ready;
    assign luma_ready = load3;

    // S3 is the output register; it only changes on a load, which keeps the
    // output payload stable while downstream is stalled.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            v3     <= 1'b0;
            m_data <= '0;
            m_last <= 1'b0;
            m_user <= 1'b0;
        end else if (load3) begin
            v3 <= luma_valid;
            if (luma_valid) begin
                m_data <= inv_map(luma);
                m_last <= luma_last;
                m_user <= luma_user;
            end
        end
    end

    assign m_valid = v3;
    assign accept  = s_valid && s_ready;

    // A frame start forces its beat to be beat 0 regardless of where the
    // counter was, so the line length is judged on cnt_next.
    always_comb begin
        cnt_base  = s_user ? 12'd0 : cnt;
        cnt_next  = cnt_base + 12'd1;
        line_full = (cnt_next == LINE_END);
        err_set   = accept && (s_last ? !line_full : line_full);
    end

    // Line counter restarts after a last beat or after a full-length line
    // that failed to end, so the checker resynchronises on its own.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (accept) begin
            if (s_last || line_full) begin
                cnt <= '0;
            end else begin
                cnt <= cnt_next;
            end
        end
    end

    // Setting takes priority so an error coinciding with a clear is not lost.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_line_err <= 1'b0;
        end else if (err_set) begin
            o_line_err <= 1'b1;
        end else if (i_clr_err) begin
            o_line_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rgb2pix.sv
// tb_rgb2pix
// Self-checking bench for rgb2pix with a four-beat line length. A negedge
// monitor keeps a scoreboard of expected outputs and a line-length model;
// each test task adds its own directed comparisons.
module tb_rgb2pix;

    localparam int LW = 4;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        s_user = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_user;
    logic        i_clr_err = 1'b0;
    logic        o_line_err;

    int          checks = 0;
    int          errors = 0;
    int          acc_count = 0;
    logic [9:0]  exp_q[$];
    logic [7:0]  out_log[$];
    logic        model_err = 1'b0;
    int          model_len = 0;
    logic        mon_set;
    logic [9:0]  mon_exp;
    logic        stall_prev = 1'b0;
    logic [9:0]  prev_out = '0;
    logic        drv_done = 1'b0;

    rgb2pix #(.LINE_WORDS(LW)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_user     (s_user),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_user     (m_user),
        .i_clr_err  (i_clr_err),
        .o_line_err (o_line_err)
    );

    always #5 i_clk = ~i_clk;

    // Reference pixel: plain integer luma, then the inverse grey table.
    function automatic logic [7:0] ref_pix(input logic [23:0] d);
        int y;
        y = (77 * int'(d[23:16]) + 150 * int'(d[15:8]) + 29 * int'(d[7:0]) + 128) / 256;
        if (y == 0) return 8'd0;
        if (y >= 254) return 8'd254;
        return 8'(y + 1);
    endfunction

    // Monitor: everything sampled here decides what happens at the next edge.
    always @(negedge i_clk) begin
        if (i_reset) begin
            exp_q.delete();
            model_err  = 1'b0;
            model_len  = 0;
            stall_prev = 1'b0;
        end else begin
            checks++;
            if (o_line_err !== model_err) begin
                errors++;
                $display("[TB] FAIL line_err_model: got %0b expected %0b at %0t", o_line_err, model_err, $time);
            end
            if (stall_prev) begin
                checks++;
                if (m_valid !== 1'b1 || {m_user, m_last, m_data} !== prev_out) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got v=%0b %h expected v=1 %h", m_valid, {m_user, m_last, m_data}, prev_out);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard: got unexpected beat %h expected none", m_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({m_user, m_last, m_data} !== mon_exp) begin
                        errors++;
                        $display("[TB] FAIL scoreboard: got %h expected %h", {m_user, m_last, m_data}, mon_exp);
                    end
                end
                out_log.push_back(m_data);
            end
            stall_prev = m_valid && !m_ready;
            prev_out   = {m_user, m_last, m_data};
            mon_set    = 1'b0;
            if (s_valid && s_ready) begin
                acc_count++;
                exp_q.push_back({s_user, s_last, ref_pix(s_data)});
                if (s_user) model_len = 0;
                model_len++;
                if (s_last) begin
                    mon_set   = (model_len != LW);
                    model_len = 0;
                end else if (model_len == LW) begin
                    mon_set   = 1'b1;
                    model_len = 0;
                end
            end
            model_err = mon_set ? 1'b1 : (i_clr_err ? 1'b0 : model_err);
        end
    end

    // Called at an active edge + 1; returns at the edge that accepted the beat + 1.
    task automatic send_beat(input logic [23:0] d, input logic l, input logic u);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        s_user  = u;
        @(negedge i_clk);
        while (!s_ready && guard < 200) begin
            @(negedge i_clk);
            guard++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout: s_ready got 0 expected 1");
        end
        @(posedge i_clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard   = 0;
        m_ready = 1'b1;
        while ((exp_q.size() != 0 || m_valid) && guard < 50) begin
            @(posedge i_clk);
            #1;
            guard++;
        end
        checks++;
        if (exp_q.size() != 0 || m_valid) begin
            errors++;
            $display("[TB] FAIL drain: pending got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic pulse_clr();
        i_clr_err = 1'b1;
        @(posedge i_clk);
        #1;
        i_clr_err = 1'b0;
    endtask

    task automatic test_reset();
        #1 i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if ({m_valid, m_data, m_last, m_user, o_line_err} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: got %h expected 000", {m_valid, m_data, m_last, m_user, o_line_err});
        end
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: got s_ready=%0b m_valid=%0b expected 1 0", s_ready, m_valid);
        end
    endtask

    task automatic test_single();
        logic [23:0] vec [6];
        logic [7:0]  expv [6];
        vec  = '{24'h000000, 24'h010101, 24'h646464, 24'hFF0000, 24'h00FF00, 24'hFFFFFF};
        expv = '{8'd0, 8'd2, 8'd101, 8'd78, 8'd150, 8'd254};
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_beat(vec[i], 1'b0, 1'b1);
            @(posedge i_clk);
            #1;
            checks++;
            if (m_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_early %0d: m_valid got %0b expected 0", i, m_valid);
            end
            @(posedge i_clk);
            #1;
            checks++;
            if (m_valid !== 1'b1 || m_data !== expv[i]) begin
                errors++;
                $display("[TB] FAIL single_latency %0d: got v=%0b d=%0d expected v=1 d=%0d", i, m_valid, m_data, expv[i]);
            end
        end
        drain();
    endtask

    task automatic test_round_trip();
        time t0;
        out_log.delete();
        m_ready = 1'b1;
        t0 = $time;
        for (int p = 2; p <= 254; p++) begin
            send_beat(24'((p - 1) * 32'h010101), ((p - 2) % 4) == 3, ((p - 2) % 4) == 0);
        end
        checks++;
        if ($time - t0 != 253 * 10) begin
            errors++;
            $display("[TB] FAIL round_trip_rate: got %0t expected %0d", $time - t0, 253 * 10);
        end
        drain();
        checks++;
        if (out_log.size() != 253) begin
            errors++;
            $display("[TB] FAIL round_trip_count: got %0d expected 253", out_log.size());
        end else begin
            for (int i = 0; i < 253; i++) begin
                checks++;
                if (out_log[i] !== 8'(i + 2)) begin
                    errors++;
                    $display("[TB] FAIL round_trip p=%0d: got %0d expected %0d", i + 2, out_log[i], i + 2);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] bp [8];
        int base;
        int guard;
        for (int i = 0; i < 8; i++) bp[i] = 24'($urandom);
        out_log.delete();
        m_ready  = 1'b0;
        base     = acc_count;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(bp[i], 1'b0, i == 0);
                drv_done = 1'b1;
            end
        join_none
        repeat (10) begin
            @(posedge i_clk);
            #1;
        end
        checks++;
        if (acc_count - base != 3 || s_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_fill: got accepted=%0d s_ready=%0b expected 3 0", acc_count - base, s_ready);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== ref_pix(bp[0])) begin
            errors++;
            $display("[TB] FAIL stall_head: got v=%0b d=%0d expected v=1 d=%0d", m_valid, m_data, ref_pix(bp[0]));
        end
        m_ready = 1'b1;
        guard = 0;
        while (!drv_done && guard < 100) begin
            @(posedge i_clk);
            #1;
            guard++;
        end
        checks++;
        if (!drv_done) begin
            errors++;
            $display("[TB] FAIL stall_release: driver done got 0 expected 1");
        end
        drain();
        checks++;
        if (out_log.size() != 8) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d expected 8", out_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (out_log[i] !== ref_pix(bp[i])) begin
                    errors++;
                    $display("[TB] FAIL stall_order %0d: got %0d expected %0d", i, out_log[i], ref_pix(bp[i]));
                end
            end
        end
    endtask

    task automatic test_framing();
        m_ready = 1'b1;
        pulse_clr();
        checks++;
        if (o_line_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_clear0: got %0b expected 0", o_line_err);
        end
        for (int ln = 0; ln < 2; ln++) begin
            for (int b = 0; b < 4; b++) send_beat(24'($urandom), b == 3, b == 0);
        end
        checks++;
        if (o_line_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_good: got %0b expected 0", o_line_err);
        end
        for (int b = 0; b < 3; b++) send_beat(24'($urandom), b == 2, b == 0);
        checks++;
        if (o_line_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_short: got %0b expected 1", o_line_err);
        end
        pulse_clr();
        checks++;
        if (o_line_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_clear: got %0b expected 0", o_line_err);
        end
        for (int b = 0; b < 5; b++) begin
            send_beat(24'($urandom), 1'b0, b == 0);
            if (b == 2) begin
                checks++;
                if (o_line_err !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL frame_run3: got %0b expected 0", o_line_err);
                end
            end
            if (b == 3) begin
                checks++;
                if (o_line_err !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL frame_run4: got %0b expected 1", o_line_err);
                end
            end
        end
        pulse_clr();
        send_beat(24'($urandom), 1'b0, 1'b1);
        i_clr_err = 1'b1;
        send_beat(24'($urandom), 1'b1, 1'b0);
        i_clr_err = 1'b0;
        checks++;
        if (o_line_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_set_wins: got %0b expected 1", o_line_err);
        end
        pulse_clr();
        drain();
    endtask

    task automatic test_random();
        logic [23:0] d;
        int guard;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    case ($urandom % 6)
                        0:       d = 24'h000000;
                        1:       d = 24'hFFFFFF;
                        default: d = 24'($urandom);
                    endcase
                    send_beat(d, ($urandom % 5) == 0, ($urandom % 7) == 0);
                    if (($urandom % 4) == 0) begin
                        @(posedge i_clk);
                        #1;
                    end
                end
                drv_done = 1'b1;
            end
            begin
                guard = 0;
                while (!drv_done && guard < 5000) begin
                    m_ready   = ($urandom % 3) != 0;
                    i_clr_err = ($urandom % 16) == 0;
                    @(posedge i_clk);
                    #1;
                    guard++;
                end
                i_clr_err = 1'b0;
            end
        join
        checks++;
        if (!drv_done) begin
            errors++;
            $display("[TB] FAIL random_done: got 0 expected 1");
        end
        drain();
    endtask

    task automatic test_reset_in_flight();
        m_ready = 1'b0;
        for (int b = 0; b < 3; b++) send_beat(24'($urandom), 1'b0, b == 0);
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL inflight_before: m_valid got %0b expected 1", m_valid);
        end
        i_reset = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL inflight_async: m_valid got %0b expected 0", m_valid);
        end
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        m_ready = 1'b1;
        out_log.delete();
        repeat (5) begin
            @(posedge i_clk);
            #1;
        end
        checks++;
        if (out_log.size() != 0 || m_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL inflight_stale: got %0d beats v=%0b expected 0 0", out_log.size(), m_valid);
        end
        for (int b = 0; b < 4; b++) send_beat(24'($urandom), b == 3, 1'b0);
        checks++;
        if (o_line_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL inflight_cnt_restart: got %0b expected 0", o_line_err);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_trip();
        test_backpressure();
        test_framing();
        test_random();
        test_reset_in_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
